// File: rtl/ps2_release_display_sched_if.sv
// Handshake/bus bundle between the PS/2 byte receiver, the release scheduler and the 4-digit display.
interface ps2_release_display_sched_if;
  logic       valid_code;
  logic [7:0] scan_code_in;
  logic       clear;
  logic [7:0] code_to_display;
  logic [3:0] seg_en;
  logic       ext_to_display;
  logic [2:0] key_count;
  logic       proto_err;

  modport master (
    output valid_code, scan_code_in, clear,
    input  code_to_display, seg_en, ext_to_display, key_count, proto_err
  );

  modport slave (
    input  valid_code, scan_code_in, clear,
    output code_to_display, seg_en, ext_to_display, key_count, proto_err
  );
endinterface

// File: rtl/ps2_release_display_sched.sv
// PS/2 set-2 release decoder feeding a 4-deep newest-first history,
// time-multiplexed onto a shared 4-digit seven-segment display.
//
// state     | meaning
// IDLE      | no prefix pending
// BREAK     | F0 seen, next byte is a released key
// EXT       | E0 seen, waiting for F0 or extended make
// EXT_BREAK | E0 F0 seen, next byte is a released extended key
module ps2_release_display_sched #(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input logic clk,
  input logic rst,
  ps2_release_display_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BREAK, EXT, EXT_BREAK} state_t;

  state_t           state;
  logic [7:0]       slot_code [4];
  logic [3:0]       slot_ext;
  logic [2:0]       count;
  logic [CNT_W-1:0] refresh_cnt;
  logic [1:0]       digit;
  logic [7:0]       code_r;
  logic [3:0]       seg_en_r;
  logic             ext_r;
  logic             err_r;

  logic [7:0] b;
  logic       err_byte;
  logic       prefix_byte;

  assign b           = bus.scan_code_in;
  assign err_byte    = (b == 8'h00) || (b == 8'hFF);
  assign prefix_byte = (b == 8'hE0) || (b == 8'hF0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      for (int i = 0; i < 4; i++) slot_code[i] <= 8'h00;
      slot_ext    <= 4'b0000;
      count       <= 3'd0;
      refresh_cnt <= '0;
      digit       <= 2'd0;
      code_r      <= 8'h00;
      seg_en_r    <= 4'b1111;
      ext_r       <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      // Scheduler runs regardless of clear/valid_code traffic.
      if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
        refresh_cnt <= '0;
        digit       <= digit + 2'd1;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end

      seg_en_r <= ({1'b0, digit} < count) ? ~(4'b0001 << digit) : 4'b1111;
      code_r   <= slot_code[digit];
      ext_r    <= slot_ext[digit];
      err_r    <= 1'b0;

      if (bus.clear) begin
        state <= IDLE;
        for (int i = 0; i < 4; i++) slot_code[i] <= 8'h00;
        slot_ext <= 4'b0000;
        count    <= 3'd0;
      end else if (bus.valid_code) begin
        if (err_byte) begin
          state <= IDLE;
          err_r <= 1'b1;
        end else begin
          case (state)
            IDLE: begin
              if (b == 8'hF0)      state <= BREAK;
              else if (b == 8'hE0) state <= EXT;
            end
            EXT: begin
              if (b == 8'hF0)      state <= EXT_BREAK;
              else if (b != 8'hE0) state <= IDLE;
            end
            BREAK, EXT_BREAK: begin
              state <= IDLE;
              if (prefix_byte) begin
                err_r <= 1'b1;
              end else begin
                for (int i = 3; i > 0; i--) slot_code[i] <= slot_code[i-1];
                slot_code[0] <= b;
                slot_ext     <= {slot_ext[2:0], state == EXT_BREAK};
                if (count != 3'd4) count <= count + 3'd1;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

  assign bus.code_to_display = code_r;
  assign bus.seg_en          = seg_en_r;
  assign bus.ext_to_display  = ext_r;
  assign bus.key_count       = count;
  assign bus.proto_err       = err_r;

endmodule

// File: tb/tb_ps2_release_display_sched.sv
// Randomized and directed bench for the PS/2 release display scheduler,
// checked every cycle against a queue-based history model.
module tb_ps2_release_display_sched;
  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ps2_release_display_sched_if bus();

  ps2_release_display_sched #(.REFRESH_DIV(DIV), .CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: history is a queue of {ext, code}, newest at the front.
  logic [8:0] hist [$];
  bit         pend_e0, pend_f0, m_valid;
  int         m_tick, m_d;
  logic [3:0] m_seg;
  logic [7:0] m_code;
  logic       m_ext, m_err;

  always @(posedge clk) begin
    if (rst) begin
      hist.delete();
      pend_e0 = 0; pend_f0 = 0;
      m_tick = 0; m_d = 0;
      m_seg = 4'hF; m_code = 8'h00; m_ext = 1'b0; m_err = 1'b0;
      m_valid = 1;
    end else if (m_valid) begin
      logic [8:0] s;
      logic [7:0] bb;
      s      = (m_d < hist.size()) ? hist[m_d] : 9'h000;
      m_seg  = (m_d < hist.size()) ? ~(4'b0001 << m_d) : 4'hF;
      m_code = s[7:0];
      m_ext  = s[8];
      m_err  = 1'b0;
      if (m_tick == DIV - 1) begin
        m_tick = 0;
        m_d = (m_d + 1) % 4;
      end else begin
        m_tick++;
      end
      bb = bus.scan_code_in;
      if (bus.clear) begin
        hist.delete();
        pend_e0 = 0; pend_f0 = 0;
      end else if (bus.valid_code) begin
        if (bb == 8'h00 || bb == 8'hFF) begin
          m_err = 1'b1; pend_e0 = 0; pend_f0 = 0;
        end else if (pend_f0) begin
          if (bb == 8'hE0 || bb == 8'hF0) m_err = 1'b1;
          else begin
            hist.push_front({pend_e0, bb});
            if (hist.size() > 4) void'(hist.pop_back());
          end
          pend_e0 = 0; pend_f0 = 0;
        end else if (bb == 8'hF0) pend_f0 = 1;
        else if (bb == 8'hE0) pend_e0 = 1;
        else pend_e0 = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("seg_en", bus.seg_en, m_seg);
      chk("code_to_display", bus.code_to_display, m_code);
      chk("ext_to_display", bus.ext_to_display, m_ext);
      chk("key_count", bus.key_count, hist.size());
      chk("proto_err", bus.proto_err, m_err);
    end
  end

  task automatic drive(input logic [7:0] c, input logic cl);
    bus.valid_code = 1'b1; bus.scan_code_in = c; bus.clear = cl;
    @(negedge clk);
    bus.valid_code = 1'b0; bus.clear = 1'b0;
  endtask

  task automatic send(input logic [7:0] c);
    drive(c, 1'b0);
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic scan_window(output logic [31:0] codes, output logic [3:0] exts,
                             output logic [3:0] seen);
    logic [3:0] pat;
    codes = '0; exts = '0; seen = '0;
    repeat (4 * DIV + 4) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        pat = 4'b0001 << i;
        if (bus.seg_en == ~pat) begin
          seen[i] = 1'b1;
          codes[8*i +: 8] = bus.code_to_display;
          exts[i] = bus.ext_to_display;
        end
      end
    end
  endtask

  logic [31:0] codes;
  logic [3:0]  exts, seen;
  logic [7:0]  rb;
  int          r;

  initial begin
    rst = 1'b1;
    bus.valid_code = 1'b0; bus.scan_code_in = 8'h00; bus.clear = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle key_count", bus.key_count, 3'd0);
    chk("idle seg_en", bus.seg_en, 4'b1111);

    send(8'h1C); send(8'hF0); send(8'h1C);
    scan_window(codes, exts, seen);
    chk("one key count", bus.key_count, 3'd1);
    chk("one key seen", seen, 4'b0001);
    chk("one key code", codes[7:0], 8'h1C);
    chk("one key ext", exts[0], 1'b0);

    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    scan_window(codes, exts, seen);
    chk("ext count", bus.key_count, 3'd2);
    chk("ext seen", seen, 4'b0011);
    chk("ext codes", codes[15:0], 16'h1C75);
    chk("ext flags", exts[1:0], 2'b01);

    foreach (codes[i]) ;
    send(8'hF0); send(8'h1C); send(8'hF0); send(8'h32); send(8'hF0); send(8'h21);
    send(8'hF0); send(8'h23); send(8'hF0); send(8'h24);
    scan_window(codes, exts, seen);
    chk("full count", bus.key_count, 3'd4);
    chk("full seen", seen, 4'b1111);
    chk("full codes", codes, 32'h32212324);

    drive(8'hF0, 1'b0); drive(8'hF0, 1'b0);
    chk("double F0 err", bus.proto_err, 1'b1);
    @(negedge clk);
    chk("double F0 err pulse", bus.proto_err, 1'b0);
    drive(8'h00, 1'b0);
    chk("null byte err", bus.proto_err, 1'b1);
    @(negedge clk);
    chk("null byte err pulse", bus.proto_err, 1'b0);
    send(8'hF0); send(8'h1C);
    repeat (2) @(negedge clk);
    chk("after err count", bus.key_count, 3'd4);

    send(8'hF0); drive(8'h29, 1'b1);
    chk("clear count", bus.key_count, 3'd0);
    chk("clear no err", bus.proto_err, 1'b0);
    scan_window(codes, exts, seen);
    chk("clear blank", seen, 4'b0000);

    send(8'hF0); send(8'h1C);
    send(8'hF0);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    send(8'h29);
    repeat (2) @(negedge clk);
    chk("rst drops break", bus.key_count, 3'd0);

    repeat (400) begin
      r = $urandom_range(0, 9);
      if (r < 3)       rb = 8'hF0;
      else if (r == 3) rb = 8'hE0;
      else if (r == 4) rb = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
      else             rb = 8'($urandom_range(1, 254));
      drive(rb, ($urandom_range(0, 29) == 0));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (20) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ps2_release_display_sched.md
Name: ps2_release_display_sched

Overview:
- Sits between the PS/2 byte receiver (valid_code/scan_code_in) and the 4-digit seven-segment driver.
- Decodes PS/2 set-2 byte sequences with a 4-state FSM covering make, break (F0) and extended (E0).
- Records only released keys into a 4-deep history buffer, newest first.
- Time-multiplexes the shared 4-digit display over that history, blanking empty digits.

Parameters:
- REFRESH_DIV, 100000, clock cycles each digit stays enabled; legal range 2..2^CNT_W.
- CNT_W, 17, width of the refresh counter; must satisfy 2^CNT_W >= REFRESH_DIV.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- valid_code, input, 1, one-cycle strobe; scan_code_in is valid in this cycle.
- scan_code_in, input, 8, received PS/2 byte.
- clear, input, 1, synchronous pulse that empties the history and returns the FSM to IDLE.
- code_to_display, output, 8, scan code for the currently enabled digit.
- seg_en, output, 4, active-low digit enables; bit0 is the rightmost digit.
- ext_to_display, output, 1, extended flag of the displayed slot.
- key_count, output, 3, number of valid history slots, 0..4.
- proto_err, output, 1, one-cycle pulse on a protocol error.

Behaviour:
- Reset (rst=1 at a clk edge):
  - FSM to IDLE; all history slots cleared to code 0x00, ext 0.
  - key_count=0, refresh counter=0, digit index=0.
  - seg_en=4'b1111, code_to_display=8'h00, ext_to_display=0, proto_err=0.
  - rst overrides every other input. Reset mid-sequence (for example after F0) discards the pending break.
- FSM: evaluated only on cycles where valid_code=1; all transitions take effect at that edge.
  - Error byte: 0x00 or 0xFF in any state -> IDLE, no push, proto_err=1 next cycle.
  - IDLE: F0 -> BREAK; E0 -> EXT; any other byte is a make code -> stay IDLE, no push.
  - EXT: F0 -> EXT_BREAK; E0 -> stay EXT; other byte is an extended make -> IDLE, no push.
  - BREAK: E0 or F0 -> IDLE with proto_err; other byte b -> push (b, ext=0), then IDLE.
  - EXT_BREAK: E0 or F0 -> IDLE with proto_err; other byte b -> push (b, ext=1), then IDLE.
- Push:
  - slot3<=slot2, slot2<=slot1, slot1<=slot0, slot0<=new entry; the old slot3 is discarded.
  - key_count increments and saturates at 4.
  - The buffer changes at the valid_code edge and is visible on outputs one cycle later.
- clear:
  - Same-cycle effect as reset for the FSM, buffer and key_count only. The refresh counter and digit index keep running.
  - clear has priority over a simultaneous push or FSM transition; that byte is dropped with no proto_err.
- Refresh scheduler:
  - Counter runs 0..REFRESH_DIV-1 and wraps.
  - On the wrap cycle the digit index increments mod 4 (3 -> 0).
  - It runs independently of valid_code.
- Outputs: registered from the digit index d and the buffer, with 1-cycle latency.
  - seg_en = ~(1<<d) when d < key_count; otherwise 4'b1111 (digit blanked, index still advances).
  - code_to_display = slot[d].code and ext_to_display = slot[d].ext, driven even when the digit is blanked.
  - Digit 0 (rightmost) shows the newest key.
- proto_err: registered pulse, high exactly one cycle after the offending byte. It never stays high for two consecutive cycles unless errors arrive back-to-back.

Test Plan:
- Reset then idle 20 cycles with REFRESH_DIV=4 -> seg_en=1111 throughout, key_count=0, code_to_display=00, digit index cycles 0..3 every 16 cycles.
- Bytes 1C, F0, 1C (one valid_code pulse each, gaps allowed) -> key_count=1; when d=0, seg_en=1110, code_to_display=1C, ext_to_display=0; digits 1..3 blanked.
- Bytes E0, 75, E0, F0, 75 -> slot0=75 with ext=1, key_count increments once only; extended make ignored.
- Release sequence F0 xx for 1C, 32, 21, 23, 24 -> key_count=4; d=0..3 show 24, 23, 21, 32 with seg_en 1110, 1101, 1011, 0111; 1C evicted.
- F0 then F0, and separately byte 00 in IDLE -> FSM IDLE, proto_err high exactly 1 cycle each time, no push; following F0 1C pushes normally.
- Assert clear in the same cycle as the final byte of F0 29 -> no push, key_count=0, all digits blank, refresh index unaffected; rst asserted after F0 then byte 29 -> no push.
